// File: rtl/wb_pkg.sv
// Shared Wishbone B3 definitions: cycle/burst type codes and the RAM slave state encoding.
// Also used by the LIMB interface for its master-side bursts.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;
  localparam logic [1:0] BTE_WRAP4   = 2'b01;
  localparam logic [1:0] BTE_WRAP8   = 2'b10;
  localparam logic [1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACK,
    ST_STALL,
    ST_GAP,
    ST_ERR
  } wb_state_t;

  // Cycle types this slave can serve; anything else is answered with err_o.
  function automatic logic cti_supported(input logic [2:0] cti);
    return (cti == CTI_CLASSIC) || (cti == CTI_CONST) ||
           (cti == CTI_INCR)    || (cti == CTI_EOB);
  endfunction

endpackage

// File: rtl/wb_burst_adr.sv
// Next-beat word address for registered-feedback bursts. Purely combinational;
// the caller owns the address register. Depth is 2^WORD_AW words.
module wb_burst_adr
  import wb_pkg::*;
#(
  parameter int WORD_AW = 4
) (
  input  logic [WORD_AW-1:0] word_adr,
  input  logic [1:0]         bte,
  input  logic [2:0]         cti,
  output logic [WORD_AW-1:0] next_adr
);

  logic [WORD_AW-1:0] wrap_mask;
  logic [WORD_AW-1:0] inc_adr;

  // Only the bits under the mask advance; bits above it stay pinned to the wrap block.
  always_comb begin
    wrap_mask = '1;
    case (bte)
      BTE_LINEAR: wrap_mask = '1;
      BTE_WRAP4:  wrap_mask = WORD_AW'(3);
      BTE_WRAP8:  wrap_mask = WORD_AW'(7);
      BTE_WRAP16: wrap_mask = WORD_AW'(15);
    endcase
  end

  assign inc_adr  = word_adr + WORD_AW'(1);
  assign next_adr = (cti == CTI_INCR) ? ((word_adr & ~wrap_mask) | (inc_adr & wrap_mask))
                                      : word_adr;

endmodule

// File: rtl/wb_burst_ram.sv
// Wishbone B3 single-port RAM slave with byte lanes, wait states and registered-feedback
// bursts. dat_o always carries the word for the beat being (or about to be) acknowledged.
module wb_burst_ram
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 6,
  parameter int WAIT_STATES = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  input  logic                    stb_i,
  input  logic                    cyc_i,
  input  logic [2:0]              cti_i,
  input  logic [1:0]              bte_i,
  output logic                    ack_o,
  output logic                    err_o
);

  localparam int SEL_W   = DATA_WIDTH / 8;
  localparam int OFF_W   = $clog2(SEL_W);
  localparam int WORD_AW = ADDR_WIDTH - OFF_W;
  localparam int DEPTH   = 1 << WORD_AW;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  wb_state_t             state_q, state_d;
  logic [WORD_AW-1:0]    adr_q, adr_d, adr_next;
  logic [3:0]            wait_q, wait_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] wr_data, rd_data;
  logic                  wr_en, ack_d, err_d, dat_load;

  if (OFF_W > 0) begin : g_unused_lanes
    logic unused_adr_lo;
    assign unused_adr_lo = ^adr_i[OFF_W-1:0];
  end

  wb_burst_adr #(.WORD_AW(WORD_AW)) u_adr (
    .word_adr (adr_q),
    .bte      (bte_i),
    .cti      (cti_i),
    .next_adr (adr_next)
  );

  assign wr_en = ack_o & cyc_i & stb_i & we_i;

  // Merged write word doubles as the bypass source so a read of the same word next beat sees it.
  always_comb begin
    wr_data = mem[adr_q];
    for (int b = 0; b < SEL_W; b++) begin
      if (sel_i[b]) wr_data[b*8 +: 8] = dat_i[b*8 +: 8];
    end
    rd_data = (wr_en && (adr_d == adr_q)) ? wr_data : mem[adr_d];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[adr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      wait_q  <= '0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      dat_o   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      wait_q  <= wait_d;
      ack_o   <= ack_d;
      err_o   <= err_d;
      if (dat_load) dat_o <= rd_data;
    end
  end

  // Dropping cyc_i abandons whatever is in flight, from any state.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    wait_d  = wait_q;
    if (!cyc_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (stb_i) begin
            if (cti_supported(cti_i)) begin
              adr_d = adr_i[ADDR_WIDTH-1:OFF_W];
              if (WAIT_STATES == 0) begin
                state_d = ST_ACK;
              end else begin
                state_d = ST_WAIT;
                wait_d  = WAIT_LOAD;
              end
            end else begin
              state_d = ST_ERR;
            end
          end
        end
        ST_WAIT: begin
          if (wait_q == 4'd0) state_d = ST_ACK;
          else                wait_d  = wait_q - 4'd1;
        end
        ST_ACK: begin
          if (!stb_i)                                        state_d = ST_STALL;
          else if ((cti_i == CTI_CONST) || (cti_i == CTI_INCR)) adr_d   = adr_next;
          else                                               state_d = ST_GAP;
        end
        ST_STALL: begin
          if (stb_i) state_d = ST_ACK;
        end
        ST_GAP:  state_d = ST_IDLE;
        ST_ERR:  state_d = ST_GAP;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ack_d    = (state_d == ST_ACK);
    err_d    = (state_d == ST_ERR);
    dat_load = (state_d == ST_ACK) || (state_d == ST_STALL);
  end

endmodule

// File: tb/tb_wb_burst_ram.sv
// Directed bench for wb_burst_ram: a zero-wait and a two-wait instance share one bus,
// read data is scoreboarded against a bench-side memory model.
module tb_wb_burst_ram;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  adr_i;
  logic [31:0] dat_i;
  logic        we_i;
  logic [3:0]  sel_i;
  logic        stb_i;
  logic        cyc_i;
  logic [2:0]  cti_i;
  logic [1:0]  bte_i;
  logic        use_w2;

  logic        cyc_w0, cyc_w2;
  logic [31:0] dat_w0, dat_w2;
  logic        ack_w0, ack_w2, err_w0, err_w2;
  logic        ack_s, err_s;
  logic [31:0] dat_s;

  logic [31:0] mdl0 [16];
  logic [31:0] mdl2 [16];
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign cyc_w0 = cyc_i & ~use_w2;
  assign cyc_w2 = cyc_i & use_w2;
  assign ack_s  = use_w2 ? ack_w2 : ack_w0;
  assign err_s  = use_w2 ? err_w2 : err_w0;
  assign dat_s  = use_w2 ? dat_w2 : dat_w0;

  wb_burst_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .WAIT_STATES(0)) dut_w0 (
    .clk(clk), .reset(reset), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_w0),
    .we_i(we_i), .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_w0),
    .cti_i(cti_i), .bte_i(bte_i), .ack_o(ack_w0), .err_o(err_w0)
  );

  wb_burst_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .WAIT_STATES(2)) dut_w2 (
    .clk(clk), .reset(reset), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_w2),
    .we_i(we_i), .sel_i(sel_i), .stb_i(stb_i), .cyc_i(cyc_w2),
    .cti_i(cti_i), .bte_i(bte_i), .ack_o(ack_w2), .err_o(err_w2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic cyc, input logic stb, input logic we, input int word,
                               input logic [31:0] dat, input logic [3:0] sel,
                               input logic [2:0] cti, input logic [1:0] bte);
    cyc_i = cyc;
    stb_i = stb;
    we_i  = we;
    adr_i = 6'(word * 4);
    dat_i = dat;
    sel_i = sel;
    cti_i = cti;
    bte_i = bte;
  endtask

  task automatic idleBus();
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 32'h0, 4'h0, CTI_CLASSIC, BTE_LINEAR);
  endtask

  function automatic void mdlWrite(input int word, input logic [31:0] d, input logic [3:0] sel);
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) begin
        if (use_w2) mdl2[word][b*8 +: 8] = d[b*8 +: 8];
        else        mdl0[word][b*8 +: 8] = d[b*8 +: 8];
      end
    end
  endfunction

  function automatic logic [31:0] mdlRead(input int word);
    return use_w2 ? mdl2[word] : mdl0[word];
  endfunction

  // Wrap blocks of 4/8/16 words; linear wraps over the whole 16-word memory.
  function automatic int tbNext(input int word, input logic [1:0] bte);
    int span;
    span = (bte == BTE_LINEAR) ? 16 : (2 << bte);
    return (word / span) * span + ((word % span) + 1) % span;
  endfunction

  // Single classic cycle from an idle slave; returns with the slave idle again.
  task automatic classic(input logic we, input int word, input logic [31:0] wdat,
                         input logic [3:0] sel, input int exp_ack, input string tag);
    int n;
    if (!we) exp_q.push_back(mdlRead(word));
    applyStimulus(1'b1, 1'b1, we, word, wdat, sel, CTI_CLASSIC, BTE_LINEAR);
    n = 0;
    @(negedge clk);
    while (ack_s !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_ack_cycle"}, 32'(n), 32'(exp_ack));
    if (ack_s === 1'b1) begin
      checkOutput({tag, "_err"}, 32'(err_s), 32'd0);
      if (we) mdlWrite(word, wdat, sel);
      else    checkOutput({tag, "_dat"}, dat_s, exp_q.pop_front());
    end
    exp_q.delete();
    tick();
    idleBus();
    tick();
  endtask

  // Incrementing burst on the zero-wait slave with an optional master stall or early cyc drop.
  task automatic runBurst(input logic we, input int start, input logic [1:0] bte, input int n,
                          input int stall_beat, input int stall_len, input int abort_after,
                          input logic [31:0] wbase, input string tag);
    int words [$];
    int w, beat, cnt, stall_cnt;
    bit aborted;
    w = start;
    for (int i = 0; i < n; i++) begin
      words.push_back(w);
      if (!we) exp_q.push_back(mdlRead(w));
      w = tbNext(w, bte);
    end
    beat = 0; cnt = 0; stall_cnt = 0; aborted = 1'b0;
    applyStimulus(1'b1, 1'b1, we, start, wbase, 4'hF, (n == 1) ? CTI_EOB : CTI_INCR, bte);
    while (beat < n && cnt < 200 && !aborted) begin
      @(negedge clk);
      if (ack_s === 1'b1 && stb_i) begin
        checkOutput({tag, "_beat_cycle"}, 32'(cnt),
                    32'(1 + beat + ((beat >= stall_beat) ? stall_len + 1 : 0)));
        if (we) mdlWrite(words[beat], dat_i, sel_i);
        else    checkOutput({tag, "_beat_dat"}, dat_s, exp_q.pop_front());
        beat++;
      end else if (!stb_i && stall_cnt >= 2) begin
        checkOutput({tag, "_stall_ack"}, 32'(ack_s), 32'd0);
        if (!we) checkOutput({tag, "_stall_dat"}, dat_s, exp_q[0]);
      end
      tick();
      cnt++;
      if (beat == abort_after) begin
        idleBus();
        aborted = 1'b1;
      end else if (beat == stall_beat && stall_cnt < stall_len) begin
        stb_i = 1'b0;
        stall_cnt++;
      end else begin
        applyStimulus(1'b1, 1'b1, we, start, wbase + 32'(beat), 4'hF,
                      (beat == n - 1) ? CTI_EOB : CTI_INCR, bte);
      end
    end
    checkOutput({tag, "_beats"}, 32'(beat), 32'(aborted ? abort_after : n));
    exp_q.delete();
    idleBus();
    tick();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    use_w2 = 1'b0;
    reset  = 1'b0;
    idleBus();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_ack_w0", 32'(ack_w0), 32'd0);
    checkOutput("rst_err_w0", 32'(err_w0), 32'd0);
    checkOutput("rst_dat_w0", dat_w0, 32'd0);
    checkOutput("rst_ack_w2", 32'(ack_w2), 32'd0);
    checkOutput("rst_dat_w2", dat_w2, 32'd0);
    reset = 1'b1;
    tick();

    $display("[TB] reset asserted mid-burst");
    classic(1'b1, 0, 32'hA5A5_5A5A, 4'hF, 1, "pre_wr");
    applyStimulus(1'b1, 1'b1, 1'b0, 0, 32'h0, 4'hF, CTI_INCR, BTE_LINEAR);
    tick();
    @(negedge clk);
    checkOutput("mid_burst_ack", 32'(ack_s), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("async_rst_ack", 32'(ack_s), 32'd0);
    checkOutput("async_rst_dat", dat_s, 32'd0);
    idleBus();
    tick();
    tick();
    reset = 1'b1;
    tick();
    classic(1'b0, 0, 32'h0, 4'h0, 1, "post_rst_rd");

    $display("[TB] preload and wrap4 read");
    runBurst(1'b1, 0, BTE_LINEAR, 16, 99, 0, 99, 32'h0, "preload");
    runBurst(1'b0, 6, BTE_WRAP4, 4, 99, 0, 99, 32'h0, "wrap4");

    $display("[TB] linear wrap from last word with stall");
    runBurst(1'b0, 15, BTE_LINEAR, 3, 1, 2, 99, 32'h0, "lin_stall");

    $display("[TB] unsupported cycle type");
    applyStimulus(1'b1, 1'b1, 1'b1, 5, 32'hDEAD_BEEF, 4'hF, 3'b011, BTE_LINEAR);
    @(negedge clk);
    checkOutput("err_c0", 32'(err_s), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("err_pulse", 32'(err_s), 32'd1);
    checkOutput("err_no_ack", 32'(ack_s), 32'd0);
    tick();
    @(negedge clk);
    checkOutput("err_drop", 32'(err_s), 32'd0);
    checkOutput("err_gap_ack", 32'(ack_s), 32'd0);
    tick();
    idleBus();
    tick();
    classic(1'b0, 5, 32'h0, 4'h0, 1, "err_mem");

    $display("[TB] write burst abandoned after two beats");
    runBurst(1'b1, 8, BTE_LINEAR, 4, 99, 0, 2, 32'h0000_00B0, "abort_wr");
    classic(1'b0, 10, 32'h0, 4'h0, 1, "abort_idle");
    runBurst(1'b0, 8, BTE_LINEAR, 3, 99, 0, 99, 32'h0, "abort_rd");

    $display("[TB] constant burst write-then-read bypass");
    applyStimulus(1'b1, 1'b1, 1'b1, 12, 32'h0000_C0DE, 4'hF, CTI_CONST, BTE_LINEAR);
    tick();
    @(negedge clk);
    checkOutput("byp_wr_ack", 32'(ack_s), 32'd1);
    mdlWrite(12, 32'h0000_C0DE, 4'hF);
    exp_q.push_back(mdlRead(12));
    tick();
    applyStimulus(1'b1, 1'b1, 1'b0, 12, 32'h0, 4'hF, CTI_EOB, BTE_LINEAR);
    @(negedge clk);
    checkOutput("byp_rd_ack", 32'(ack_s), 32'd1);
    checkOutput("byp_rd_dat", dat_s, exp_q.pop_front());
    tick();
    idleBus();
    tick();

    $display("[TB] two wait states, partial byte write");
    use_w2 = 1'b1;
    classic(1'b1, 3, 32'hFFFF_FFFF, 4'hF, 3, "w2_fill");
    classic(1'b1, 3, 32'h1234_5678, 4'b0011, 3, "w2_wr");
    classic(1'b0, 3, 32'h0, 4'h0, 3, "w2_rd");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_burst_ram.md
# wb_burst_ram

Parametrised Wishbone B3 single-port RAM slave, successor to the fixed-size classic-only RAM behind the LIMB bridge. Adds configurable data width, depth and wait states, byte-lane writes, and registered-feedback bursts (constant and incrementing, linear or 4/8/16-beat wrap). The LIMB bridge and future bus masters use it to stream data without a per-word handshake gap.

## Interface
- DATA_WIDTH, 32: data bus width; a multiple of 8, in the range 8..64.
- ADDR_WIDTH, 6: byte-address width; depth = 2^ADDR_WIDTH / (DATA_WIDTH/8) words.
- WAIT_STATES, 0: extra cycles before the first ack of a cycle; 0..15.

- clk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- adr_i  in  ADDR_WIDTH  byte address; the low log2(DATA_WIDTH/8) bits are ignored.
- dat_i  in  DATA_WIDTH  write data.
- dat_o  out  DATA_WIDTH  read data, registered.
- we_i  in  1  write enable.
- sel_i  in  DATA_WIDTH/8  byte-lane enables.
- stb_i  in  1  strobe.
- cyc_i  in  1  bus cycle.
- cti_i  in  3  cycle type: 000 classic, 001 constant, 010 incrementing, 111 end-of-burst.
- bte_i  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
- ack_o  out  1  transfer acknowledge, registered.
- err_o  out  1  error terminate, registered.

## Operation
- Reset values: ack_o=0, err_o=0, dat_o=0, state IDLE, wait counter 0. Memory contents are not reset.
- A transfer completes at the rising edge where cyc_i & stb_i & (ack_o | err_o).
- A write happens at that edge only if ack_o=1. It writes dat_i to the bytes enabled by sel_i, at the current word address.
- State machine:
  - IDLE:
    - On cyc_i & stb_i with a supported cti_i, latch the word address into the burst counter.
    - If WAIT_STATES=0, go to ACK. Otherwise go to WAIT and load the counter with WAIT_STATES-1.
    - An unsupported cti_i (011..110) goes to ERR.
  - WAIT: decrement the counter each cycle; go to ACK when it reaches 0.
  - ACK: ack_o=1; dat_o = mem[counter].
    - Classic (000) or end-of-burst (111) beat: go to GAP.
    - 001 or 010 with stb_i=1: stay in ACK. For 010, advance the counter; for 001, hold it. Prefetch dat_o from the next address so that ack_o stays high every cycle.
    - stb_i=0 while cyc_i=1 (master stall): go to STALL, counter held.
  - STALL: ack_o=0; dat_o holds the next beat. When stb_i returns, go to ACK with no wait states.
  - GAP: ack_o=0 for one cycle, then IDLE. This guarantees a deasserted ack between classic cycles.
  - ERR: err_o=1 for one cycle, no write, then GAP.
- cyc_i=0 in any state: go to IDLE next cycle, with ack_o and err_o 0. No write occurs at an edge where cyc_i=0. A burst that is cut short is abandoned.
- Address counter advance:
  - Linear: word+1, wrapping modulo depth.
  - wrapN: only the low log2(N) word bits increment; the upper bits stay fixed.
- adr_i is sampled only at the start of a cycle. Later beats use the internal counter.
- Wait states apply only to the first beat of a cycle.

## Timing
- Classic read or write, WAIT_STATES=W: stb_i rises at cycle 0 and ack_o is high in cycle W+1.
  - For a read, dat_o is valid in the same cycle as ack_o.
  - For a write, memory updates at the end of cycle W+1.
- Back-to-back classic cycles take W+3 cycles each (request, W waits, ack, gap).
- Incrementing burst of N beats: first ack in cycle W+1, then one beat per cycle. The burst ends with the 111 beat, followed by one gap cycle.
- Read-after-write to the same word in the next beat returns the new data (write-first bypass).
- err_o and ack_o are never high in the same cycle.

## Structure
- Shared package wb_pkg: CTI_CLASSIC/CONST/INCR/EOB and BTE_LINEAR/WRAP4/WRAP8/WRAP16 localparams, plus the state encoding. The LIMB interface reuses the package for its master-side bursts.
- One sub-module, wb_burst_adr: a purely combinational next-address function of (word address, bte, cti, depth). It is instantiated once; the state machine owns the register.
- The memory array, wait counter and state machine live in the top module.

## Test plan
- Reset asserted mid-burst: ack_o drops to 0 asynchronously. After release, a classic read of word 0 after a prior write of 0xA5A5_5A5A returns that value with ack in cycle 1.
- WAIT_STATES=2: a classic write of 0x1234_5678, sel=0011, onto 0xFFFF_FFFF. ack appears in cycle 3; a readback returns 0xFFFF_5678.
- wrap4 incrementing read starting at word 6, preloaded with value = index: beats return 6, 7, 4, 5 on consecutive cycles, and ack stays high for 4 cycles.
- Linear burst from the last word (depth 16): data returns 15, then 0, 1. A master stall of 2 cycles mid-burst drops ack, holds the next data, and the burst resumes without wait states.
- cti=011: err_o pulses high for one cycle, ack_o stays 0, and memory is unchanged.
- cyc_i dropped during a write burst after 2 beats: only 2 words are written, and IDLE is reached the next cycle.
